// File: rtl/trigger_gen.sv
// trigger_gen: multi-channel periodic trigger generator.
// A master period counter drives NUM_CH phase-delayed, width-programmable
// strobes, in continuous or N-period burst mode. Configuration is latched
// into shadow registers by load_in and only accepted while idle.
module trigger_gen #(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 24,
  parameter int DEFAULT_PERIOD = 150000,
  parameter int BURST_W        = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    load_in,
  input  logic [CNT_W-1:0]        period_in,
  input  logic [CNT_W-1:0]        width_in,
  input  logic [NUM_CH*CNT_W-1:0] delay_in,
  input  logic                    mode_in,
  input  logic [BURST_W-1:0]      burst_in,
  input  logic                    start_in,
  input  logic                    stop_in,
  output logic [NUM_CH-1:0]       trigger_out,
  output logic                    frame_out,
  output logic                    busy_out,
  output logic                    done_out,
  output logic                    cfg_err_out
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_nxt;

  // Shadow configuration
  logic [CNT_W-1:0]        period_q;
  logic [CNT_W-1:0]        width_q;
  logic [NUM_CH*CNT_W-1:0] delay_q;
  logic                    mode_q;
  logic [BURST_W-1:0]      burst_q;
  logic                    cfg_err_q;

  // Run-time counters and output registers
  logic [CNT_W-1:0]               cnt;
  logic [BURST_W-1:0]             per_cnt;
  logic [NUM_CH-1:0][CNT_W-1:0]   wcnt;
  logic [NUM_CH-1:0]              trig_q;
  logic                           frame_q;
  logic                           done_q;

  logic cfg_ok;
  logic period_end;
  logic burst_end;
  logic keep_run;

  // Validate the configuration presented on the inputs
  always_comb begin
    cfg_ok = 1'b1;
    if (period_in < CNT_W'(2)) cfg_ok = 1'b0;
    if (width_in == '0 || width_in >= period_in) cfg_ok = 1'b0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (delay_in[c*CNT_W +: CNT_W] >= period_in) cfg_ok = 1'b0;
    end
    if (mode_in && burst_in == '0) cfg_ok = 1'b0;
  end

  // Next-state logic; stop has priority over both start and burst completion
  always_comb begin
    state_nxt  = state;
    period_end = (cnt == period_q - CNT_W'(1));
    burst_end  = mode_q && period_end && (per_cnt == burst_q - BURST_W'(1));
    case (state)
      IDLE: if (start_in && !stop_in) state_nxt = RUN;
      RUN:  if (stop_in || burst_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Datapath only advances while the run continues past this edge, so the
    // leaving edge clears counters and truncates any pulse in progress.
    keep_run = (state == RUN) && (state_nxt == RUN);
  end

  // State register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  // Shadow configuration load, accepted only while idle
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      period_q  <= CNT_W'(DEFAULT_PERIOD);
      width_q   <= CNT_W'(1);
      delay_q   <= '0;
      mode_q    <= 1'b0;
      burst_q   <= BURST_W'(1);
      cfg_err_q <= 1'b0;
    end else if (state == IDLE && load_in) begin
      if (cfg_ok) begin
        period_q  <= period_in;
        width_q   <= width_in;
        delay_q   <= delay_in;
        mode_q    <= mode_in;
        burst_q   <= burst_in;
        cfg_err_q <= 1'b0;
      end else begin
        cfg_err_q <= 1'b1;
      end
    end
  end

  // Master period counter, completed-period counter, frame and done strobes
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt     <= '0;
      per_cnt <= '0;
      frame_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state == RUN) && burst_end && !stop_in;
      if (keep_run) begin
        cnt     <= period_end ? '0 : cnt + CNT_W'(1);
        per_cnt <= period_end ? per_cnt + BURST_W'(1) : per_cnt;
        frame_q <= (cnt == '0);
      end else begin
        cnt     <= '0;
        per_cnt <= '0;
        frame_q <= 1'b0;
      end
    end
  end

  // Per-channel pulse generators: start on delay match, hold for width cycles
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      trig_q <= '0;
      wcnt   <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (!keep_run) begin
          trig_q[c] <= 1'b0;
          wcnt[c]   <= '0;
        end else if (cnt == delay_q[c*CNT_W +: CNT_W]) begin
          trig_q[c] <= 1'b1;
          wcnt[c]   <= width_q - CNT_W'(1);
        end else if (trig_q[c]) begin
          if (wcnt[c] == '0) trig_q[c] <= 1'b0;
          else               wcnt[c]   <= wcnt[c] - CNT_W'(1);
        end
      end
    end
  end

  assign trigger_out = trig_q;
  assign frame_out   = frame_q;
  assign busy_out    = (state == RUN);
  assign done_out    = done_q;
  assign cfg_err_out = cfg_err_q;

endmodule

// File: tb/tb_trigger_gen.sv
// tb_trigger_gen: directed test of trigger_gen.
// Each run is captured as 32-cycle bit windows (bit k-1 = cycle t+k after
// the start edge t) and compared with hand-computed patterns.
module tb_trigger_gen;

  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 24;
  localparam int BURST_W = 16;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    load_in;
  logic [CNT_W-1:0]        period_in;
  logic [CNT_W-1:0]        width_in;
  logic [NUM_CH*CNT_W-1:0] delay_in;
  logic                    mode_in;
  logic [BURST_W-1:0]      burst_in;
  logic                    start_in;
  logic                    stop_in;

  logic [NUM_CH-1:0] trigger_out, d_trigger;
  logic              frame_out, busy_out, done_out, cfg_err_out;
  logic              d_frame, d_busy, d_done, d_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] w_trig [NUM_CH];
  logic [31:0] w_frame, w_busy, w_done, w_dframe, w_dtrig0;

  // Small default period so the reset-default behaviour is checked exactly
  trigger_gen #(.DEFAULT_PERIOD(20)) dut (
    .clk_in(clk), .rst_in(rst), .load_in(load_in), .period_in(period_in),
    .width_in(width_in), .delay_in(delay_in), .mode_in(mode_in),
    .burst_in(burst_in), .start_in(start_in), .stop_in(stop_in),
    .trigger_out(trigger_out), .frame_out(frame_out), .busy_out(busy_out),
    .done_out(done_out), .cfg_err_out(cfg_err_out)
  );

  // Stock parameters (150000-cycle default period)
  trigger_gen dut_def (
    .clk_in(clk), .rst_in(rst), .load_in(load_in), .period_in(period_in),
    .width_in(width_in), .delay_in(delay_in), .mode_in(mode_in),
    .burst_in(burst_in), .start_in(start_in), .stop_in(stop_in),
    .trigger_out(d_trigger), .frame_out(d_frame), .busy_out(d_busy),
    .done_out(d_done), .cfg_err_out(d_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_cfg(input int p, input int w, input int d3, input int d2,
                         input int d1, input int d0, input bit m, input int b);
    period_in = CNT_W'(p);
    width_in  = CNT_W'(w);
    delay_in  = {CNT_W'(d3), CNT_W'(d2), CNT_W'(d1), CNT_W'(d0)};
    mode_in   = m;
    burst_in  = BURST_W'(b);
  endtask

  task automatic load_pulse();
    load_in = 1'b1;
    tick();
    load_in = 1'b0;
  endtask

  task automatic stop_pulse();
    stop_in = 1'b1;
    tick();
    stop_in = 1'b0;
    tick();
  endtask

  // Start at edge t (optionally with a load), record cycles t+1..t+32;
  // stop_at / load_at raise that strobe during the given cycle (0 = never)
  task automatic run_window(input int stop_at, input int load_at, input bit load_start);
    for (int c = 0; c < NUM_CH; c++) w_trig[c] = '0;
    w_frame = '0; w_busy = '0; w_done = '0; w_dframe = '0; w_dtrig0 = '0;
    start_in = 1'b1;
    load_in  = load_start;
    for (int k = 1; k <= 32; k++) begin
      tick();
      start_in = 1'b0;
      for (int c = 0; c < NUM_CH; c++) w_trig[c][k-1] = trigger_out[c];
      w_frame[k-1]  = frame_out;
      w_busy[k-1]   = busy_out;
      w_done[k-1]   = done_out;
      w_dframe[k-1] = d_frame;
      w_dtrig0[k-1] = d_trigger[0];
      load_in = (k == load_at);
      stop_in = (k == stop_at);
    end
    load_in = 1'b0;
    stop_in = 1'b0;
  endtask

  initial begin
    int nf, ndf;
    rst = 1'b1; load_in = 1'b0; start_in = 1'b0; stop_in = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 1'b0, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    check_val("rst_outs",     32'({trigger_out, frame_out, busy_out, done_out, cfg_err_out}), 32'h0);
    check_val("rst_outs_def", 32'({d_trigger, d_frame, d_busy, d_done, d_err}), 32'h0);

    // Default configuration after reset
    run_window(0, 0, 1'b0);
    check_val("def_frame", w_frame,   32'h00200002);
    check_val("def_trig0", w_trig[0], 32'h00200002);
    check_val("def_trig3", w_trig[3], 32'h00200002);
    check_val("def_busy",  w_busy,    32'hFFFFFFFF);
    check_val("def_done",  w_done,    32'h0);
    check_val("def150k_frame", w_dframe, 32'h00000002);
    check_val("def150k_trig0", w_dtrig0, 32'h00000002);
    nf = 0; ndf = 0;
    for (int k = 0; k < 2000; k++) begin
      tick();
      nf  += int'(frame_out);
      ndf += int'(d_frame);
    end
    check_val("def_frame_count",     32'(nf),  32'd100);
    check_val("def150k_frame_count", 32'(ndf), 32'd0);
    stop_pulse();
    check_val("def_stopped", 32'({trigger_out, busy_out}), 32'h0);

    // Continuous, period 10, width 3, delays 0/2/5/8
    set_cfg(10, 3, 8, 5, 2, 0, 1'b0, 1);
    load_pulse();
    check_val("p10_err", 32'(cfg_err_out), 32'h0);
    run_window(0, 0, 1'b0);
    check_val("p10_trig0", w_trig[0], 32'h80E0380E);
    check_val("p10_trig1", w_trig[1], 32'h0380E038);
    check_val("p10_trig2", w_trig[2], 32'h1C0701C0);
    check_val("p10_trig3", w_trig[3], 32'hE0380E00);
    check_val("p10_frame", w_frame,   32'h80200802);
    check_val("p10_busy",  w_busy,    32'hFFFFFFFF);
    stop_pulse();
    check_val("p10_stopped", 32'({trigger_out, frame_out, busy_out, done_out}), 32'h0);

    // Rejected loads keep the old config
    set_cfg(10, 10, 8, 5, 2, 0, 1'b0, 1);
    load_pulse();
    check_val("err_width", 32'(cfg_err_out), 32'h1);
    set_cfg(10, 3, 8, 5, 12, 0, 1'b0, 1);
    load_pulse();
    check_val("err_delay", 32'(cfg_err_out), 32'h1);
    set_cfg(4, 1, 0, 0, 0, 0, 1'b0, 1);
    run_window(0, 5, 1'b0);   // valid load during RUN must be ignored
    check_val("kept_frame",   w_frame,   32'h80200802);
    check_val("kept_trig3",   w_trig[3], 32'hE0380E00);
    check_val("err_run_load", 32'(cfg_err_out), 32'h1);
    stop_pulse();
    load_pulse();
    check_val("err_clear", 32'(cfg_err_out), 32'h0);
    set_cfg(4, 1, 0, 0, 0, 0, 1'b1, 0);
    load_pulse();
    check_val("err_burst0", 32'(cfg_err_out), 32'h1);

    // Burst of 3 periods, config loaded together with start
    set_cfg(8, 1, 7, 2, 1, 0, 1'b1, 3);
    run_window(0, 0, 1'b1);
    check_val("burst_frame", w_frame,   32'h00020202);
    check_val("burst_trig0", w_trig[0], 32'h00020202);
    check_val("burst_trig1", w_trig[1], 32'h00040404);
    check_val("burst_trig2", w_trig[2], 32'h00080808);
    check_val("burst_trig3", w_trig[3], 32'h00010100);
    check_val("burst_busy",  w_busy,    32'h00FFFFFF);
    check_val("burst_done",  w_done,    32'h01000000);
    check_val("burst_err",   32'(cfg_err_out), 32'h0);

    // Stop in the middle of a pulse, then restart from counter 0
    set_cfg(20, 5, 0, 0, 0, 0, 1'b0, 1);
    load_pulse();
    run_window(3, 0, 1'b0);
    check_val("stop_trig0", w_trig[0], 32'h00000006);
    check_val("stop_frame", w_frame,   32'h00000002);
    check_val("stop_busy",  w_busy,    32'h00000007);
    check_val("stop_done",  w_done,    32'h0);
    run_window(0, 0, 1'b0);
    check_val("restart_trig0", w_trig[0], 32'h03E0003E);
    check_val("restart_frame", w_frame,   32'h00200002);
    stop_pulse();

    // Asynchronous reset in the middle of a burst
    set_cfg(8, 1, 7, 2, 1, 0, 1'b1, 3);
    load_pulse();
    set_cfg(8, 0, 7, 2, 1, 0, 1'b1, 3);
    load_pulse();
    check_val("err_width0", 32'(cfg_err_out), 32'h1);
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    tick();
    check_val("pre_rst_frame", 32'({trigger_out[0], frame_out, busy_out}), 32'h7);
    #3 rst = 1'b1;
    #1;
    check_val("async_rst",     32'({trigger_out, frame_out, busy_out, done_out, cfg_err_out}), 32'h0);
    check_val("async_rst_def", 32'({d_trigger, d_frame, d_busy, d_done, d_err}), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    run_window(0, 0, 1'b0);
    check_val("post_rst_frame", w_frame,   32'h00200002);
    check_val("post_rst_trig3", w_trig[3], 32'h00200002);
    check_val("post_rst_busy",  w_busy,    32'hFFFFFFFF);
    check_val("post_rst_def150k", w_dframe, 32'h00000002);
    stop_pulse();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/trigger_gen.md
Name: trigger_gen

Overview:
Parametrised multi-channel periodic trigger generator; the next generation of the fixed 1 kHz single-pulse trigger. A master period counter running on clk_in (150 MHz) drives NUM_CH outputs, each with a programmable phase delay and pulse width. Supports continuous and N-period burst modes. Sits between the control/register interface and the acquisition and excitation blocks, which need phase-aligned strobes.

Parameters:
NUM_CH, 4, number of trigger output channels
CNT_W, 24, width of period, delay and width counters
DEFAULT_PERIOD, 150000, reset value of period (1 kHz at 150 MHz)
BURST_W, 16, width of the burst count

Ports:
clk_in  input  1  system clock, 150 MHz
rst_in  input  1  reset; asynchronous, active-high
load_in  input  1  one-cycle strobe; latch the configuration inputs into shadow registers
period_in  input  CNT_W  period in cycles
width_in  input  CNT_W  pulse width in cycles, shared by all channels
delay_in  input  NUM_CH*CNT_W  per-channel delay; channel c occupies bits [c*CNT_W +: CNT_W]
mode_in  input  1  0 = continuous, 1 = burst
burst_in  input  BURST_W  number of periods per burst
start_in  input  1  one-cycle strobe; start generation
stop_in  input  1  one-cycle strobe; abort generation
trigger_out  output  NUM_CH  per-channel trigger pulses
frame_out  output  1  one-cycle pulse at each period start
busy_out  output  1  high while in RUN
done_out  output  1  one-cycle pulse when a burst completes
cfg_err_out  output  1  sticky flag: last load was rejected

Behaviour:
- Reset (asynchronous, active-high):
  - FSM = IDLE.
  - All outputs = 0.
  - Shadow config: period = DEFAULT_PERIOD, width = 1, all delays = 0, mode = continuous, burst = 1.
  - With no load after reset, start_in reproduces the legacy behaviour: 1-cycle pulse every 150000 cycles.
- FSM has two states, IDLE and RUN. busy_out = (state == RUN), registered.
- load_in:
  - Honoured only in IDLE; ignored in RUN. An ignored load leaves cfg_err_out unchanged.
  - Validation:
    - period_in >= 2.
    - 1 <= width_in < period_in.
    - Every delay_c < period_in.
    - burst_in >= 1 when mode_in = 1.
  - Valid: shadow updated, cfg_err_out cleared, next edge.
  - Invalid: shadow unchanged, cfg_err_out set, next edge.
- IDLE -> RUN:
  - start_in sampled at edge t moves to RUN; the master counter is 0 during cycle t+1.
  - start_in and stop_in high together: stop wins, stay in IDLE.
  - load_in and start_in high together: the load takes effect and the run uses the new config (or the old config if the load was rejected).
- Master counter:
  - Counts 0 .. period-1, then wraps to 0.
  - Widths: CNT_W bits, no overflow possible because period <= 2^CNT_W - 1.
- frame_out: registered, high for exactly one cycle, in the cycle after each counter == 0.
- Channel c:
  - When counter == delay_c, the pulse starts: trigger_out[c] is high from the next cycle for exactly width cycles. This gives a fixed 1-cycle registered latency, identical to frame_out.
  - Pulses may span the period wrap.
  - With delay_c = 0, trigger_out[c] is coincident with frame_out.
- Continuous mode: runs until stop_in.
- Burst mode:
  - Counts completed periods.
  - When counter == period-1 of period number burst, the FSM goes to IDLE at the next edge.
  - done_out pulses for 1 cycle in the first IDLE cycle.
  - Any pulse still in progress is truncated.
- stop_in in RUN:
  - IDLE at the next edge.
  - All trigger_out and frame_out are 0 from that cycle.
  - Counter cleared; done_out not asserted.
- start_in in RUN is ignored.
- rst_in asserted mid-run: immediate return to reset values, including the shadow config.

Test Plan:
- Reset, start_in at t with default config -> trigger_out[0] and frame_out high for 1 cycle at t+2, t+150002, t+300002; busy_out = 1 from t+1.
- Load period = 10, width = 3, delays 0/2/5/8, continuous, then start at t:
  - ch0 high at t+2..t+4.
  - ch2 high at t+7..t+9.
  - ch3 high at t+10..t+12, which wraps across the period boundary.
  - Pattern repeats every 10 cycles.
- Burst: period = 8, width = 1, burst = 3, delay0 = 0, start at t -> exactly 3 frame_out pulses (t+2, t+10, t+18); busy_out falls at t+25; done_out high at t+25 only.
- stop_in mid-pulse (ch0 width = 5, stop on its 2nd high cycle) -> trigger_out = 0 next cycle; done_out stays 0; a new start_in restarts with counter = 0.
- Invalid loads:
  - width = 10 with period = 10 -> cfg_err_out = 1, old config retained.
  - delay = 12 -> same result.
  - A later valid load clears cfg_err_out; a load during RUN is ignored.
- Async reset asserted mid-burst between clock edges -> all outputs 0 immediately; after release, start_in yields the 150000-cycle default behaviour.
